// File: rtl/addsub_pkg.sv
// Shared types for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef struct packed {
        logic carry_out;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

endpackage

// File: rtl/addsub_stage.sv
// One carry-chunk stage of addsub_pipe: adds chunk IDX and carries operands/partial sum forward.
// ADDSUB_PIPE_SATURATE_EN enables clamping of the final sum on signed overflow.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output flags_t           flags_out
);

    localparam int unsigned C = WIDTH / STAGES;

    logic [C:0]       chunk;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_fin;
    logic [WIDTH-1:0] sum_d;
    logic             ovf;
    flags_t           flags_d;

    logic             valid_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    flags_t           flags_q;

    assign chunk = {1'b0, a_in[IDX*C +: C]} + {1'b0, b_in[IDX*C +: C]} + {{C{1'b0}}, carry_in};

    always_comb begin
        sum_next = sum_in;
        sum_next[IDX*C +: C] = chunk[C-1:0];
        // b_in is already b or ~b, so this is the plain signed-add overflow rule.
        ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_next[WIDTH-1] != a_in[WIDTH-1]);
`ifdef ADDSUB_PIPE_SATURATE_EN
        if (ovf) begin
            sum_fin = a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_fin = sum_next;
        end
`else
        sum_fin = sum_next;
`endif
        flags_d.carry_out = chunk[C];
        flags_d.overflow  = ovf;
        flags_d.zero      = (sum_fin == '0);
        flags_d.negative  = sum_fin[WIDTH-1];
        if (IDX == STAGES - 1) begin
            sum_d = sum_fin;
        end else begin
            sum_d = sum_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            flags_q <= '0;
        end else if (!stall) begin
            valid_q <= in_valid;
            a_q     <= a_in;
            b_q     <= b_in;
            sum_q   <= sum_d;
            carry_q <= chunk[C];
            flags_q <= flags_d;
        end
    end

    assign out_valid = valid_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign flags_out = flags_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with valid/ready handshake, one carry chunk per stage.
// ADDSUB_PIPE_SATURATE_EN (in addsub_stage) clamps the sum on signed overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    logic             stall;
    logic [STAGES:0]  pv;
    logic [STAGES:0]  pc;
    logic [WIDTH-1:0] pa [STAGES+1];
    logic [WIDTH-1:0] pb [STAGES+1];
    logic [WIDTH-1:0] ps [STAGES+1];
    flags_t           pf [STAGES];

    // Subtraction is a + ~b + 1: invert b up front and feed op as the first carry-in.
    assign pv[0] = in_valid;
    assign pa[0] = a;
    assign pb[0] = b ^ {WIDTH{op == OP_SUB}};
    assign ps[0] = '0;
    assign pc[0] = (op == OP_SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .stall    (stall),
            .in_valid (pv[k]),
            .a_in     (pa[k]),
            .b_in     (pb[k]),
            .sum_in   (ps[k]),
            .carry_in (pc[k]),
            .out_valid(pv[k+1]),
            .a_out    (pa[k+1]),
            .b_out    (pb[k+1]),
            .sum_out  (ps[k+1]),
            .carry_out(pc[k+1]),
            .flags_out(pf[k])
        );
    end

    assign out_valid = pv[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign sum       = ps[STAGES];
    assign carry_out = pf[STAGES-1].carry_out;
    assign overflow  = pf[STAGES-1].overflow;
    assign zero      = pf[STAGES-1].zero;
    assign negative  = pf[STAGES-1].negative;

endmodule
